prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000: byte address of first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 1024: largest accepted program length in words.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse to begin a load; ignored unless in IDLE, DONE or ERROR.
REQ-006 SHALL have port rx_valid, input, 1: byte stream valid.
REQ-007 SHALL have port rx_data, input, 8: byte stream data.
REQ-008 SHALL have port rx_ready, output, 1: byte accepted on any cycle where rx_valid && rx_ready.
REQ-009 SHALL have port inst_we, output, 1: instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port inst_wr_addr, output, 32: instruction-memory byte address.
REQ-011 SHALL have port inst_wr_data, output, 32: instruction word.
REQ-012 SHALL have port core_reset, output, 1: holds the processor core in reset while loading.
REQ-013 SHALL have port done, output, 1: program loaded and checksum good.
REQ-014 SHALL have port err, output, 1: load failed (length or checksum).

Function
REQ-015 Stream format SHALL be: 4-byte word count N (little-endian), N x 4 payload bytes (each word little-endian), 1 checksum byte = XOR of all payload bytes.
REQ-016 States SHALL be IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR + start -> LEN; byte counter, word index, checksum cleared; done and err cleared.
REQ-018 LEN: after 4th accepted byte, N > MAX_WORDS -> ERROR; N = 0 -> CSUM; else -> DATA.
REQ-019 DATA: after 4th byte of a word -> WRITE; checksum XORs every payload byte as accepted.
REQ-020 WRITE SHALL last exactly one cycle: inst_we=1, inst_wr_addr = ADDR_BASE + 4*index (32-bit wrap), inst_wr_data = assembled word; index increments; index = N after increment -> CSUM, else -> DATA.
REQ-021 rx_ready SHALL be 1 only in LEN, DATA, CSUM; 0 in WRITE, IDLE, DONE, ERROR.
REQ-022 Throughput SHALL be one word per 5 cycles at best (4 byte cycles + 1 write cycle).
REQ-023 rx_valid low SHALL stall the FSM indefinitely with no state loss.
REQ-024 CSUM: accepted byte equal to running checksum -> DONE, else -> ERROR.
REQ-025 core_reset SHALL be 1 in IDLE, LEN, DATA, WRITE, CSUM, ERROR; 0 only in DONE.
REQ-026 done SHALL be 1 only in DONE; err 1 only in ERROR; both held until next start or reset.
REQ-027 inst_we SHALL be 0 outside WRITE; inst_wr_addr/inst_wr_data SHALL hold last written values otherwise.
REQ-028 start during LEN/DATA/WRITE/CSUM SHALL be ignored.

Reset
REQ-029 reset SHALL force state IDLE, rx_ready=0, inst_we=0, inst_wr_addr=0, inst_wr_data=0, core_reset=1, done=0, err=0, counters and checksum 0, asynchronously.
REQ-030 reset asserted mid-load SHALL abandon the load; already-written words are not retracted.

Structure
REQ-031 State enum, stream-format constants (LEN_BYTES=4, WORD_BYTES=4) SHALL live in shared package loader_pkg.
REQ-032 Byte-to-word assembly SHALL be sub-module byte_packer (shift in 8 bits, little-endian, 2-bit count, word_ready output).
REQ-033 The 32-bit data/address width SHALL use the shared register-width definition.

Verification
REQ-034 start; bytes 01 00 00 00, 13 00 00 00, 13 -> one inst_we with addr 0x0, data 0x00000013; done=1, core_reset=0.
REQ-035 N=2, words 0x00500093, 0x00108113, correct XOR -> writes at 0x0 and 0x4, then done; rx_ready 0 during each write cycle.
REQ-036 N=1, bad checksum byte -> err=1, done=0, core_reset=1.
REQ-037 N=MAX_WORDS+1 -> ERROR after 4th length byte, no inst_we ever.
REQ-038 rx_valid toggled randomly during N=3 load -> identical writes to unstalled run; N=0 with checksum 00 -> done, no writes.
REQ-039 reset asserted after 2nd payload byte -> immediate IDLE, core_reset=1; fresh start then loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, stream-format constants and register width for the program loader
package loader_pkg;
  localparam int XLEN = 32;
  localparam int LEN_BYTES = 4;
  localparam int WORD_BYTES = 4;
  typedef logic [XLEN-1:0] word_t;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR} state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream
module byte_packer
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       shift,
  input  logic [7:0] din,
  output word_t      word,
  output logic       word_ready
);
  logic [1:0] cnt;
  word_t sr;
  assign word = {din, sr[XLEN-1:8]};
  assign word_ready = shift && cnt == 2'(WORD_BYTES - 1);
  // shift the accepted byte in at the top so the first byte ends up least significant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sr <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
      sr <= word;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed byte stream and writes it into instruction memory
module prog_loader
  import loader_pkg::*;
#(
  parameter word_t ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       inst_we,
  output word_t      inst_wr_addr,
  output word_t      inst_wr_data,
  output logic       core_reset,
  output logic       done,
  output logic       err
);
  state_t state, nxt;
  word_t n, idx, pk_word;
  logic [7:0] csum;
  logic pk_ready, acc, go;
  assign acc = rx_valid && rx_ready;
  assign go = start && (state == IDLE || state == DONE || state == ERROR);
  byte_packer u_pack (
    .clk(clk),
    .reset(reset),
    .clr(go),
    .shift(acc && (state == LEN || state == DATA)),
    .din(rx_data),
    .word(pk_word),
    .word_ready(pk_ready)
  );
  // next-state selection; the length and data words are judged on the byte that completes them
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: nxt = go ? LEN : state;
      LEN: nxt = !pk_ready ? LEN : pk_word > word_t'(MAX_WORDS) ? ERROR : pk_word == '0 ? CSUM : DATA;
      DATA: nxt = pk_ready ? WRITE : DATA;
      WRITE: nxt = idx + 1 == n ? CSUM : DATA;
      CSUM: nxt = !acc ? CSUM : rx_data == csum ? DONE : ERROR;
      default: nxt = IDLE;
    endcase
  end
  // state, counters and outputs registered from the upcoming state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rx_ready <= 1'b0;
      inst_we <= 1'b0;
      inst_wr_addr <= '0;
      inst_wr_data <= '0;
      core_reset <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
      n <= '0;
      idx <= '0;
      csum <= '0;
    end else begin
      state <= nxt;
      rx_ready <= nxt == LEN || nxt == DATA || nxt == CSUM;
      inst_we <= nxt == WRITE;
      core_reset <= nxt != DONE;
      done <= nxt == DONE;
      err <= nxt == ERROR;
      if (state == DATA && pk_ready) begin
        inst_wr_addr <= ADDR_BASE + (idx << 2);
        inst_wr_data <= pk_word;
      end
      if (state == LEN && pk_ready) n <= pk_word;
      if (go) begin
        idx <= '0;
        csum <= '0;
      end else begin
        if (state == DATA && acc) csum <= csum ^ rx_data;
        if (state == WRITE) idx <= idx + 1;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed load scenarios with hand-computed write traces and final status
module tb_prog_loader;
  import loader_pkg::*;
  logic clk = 0, reset = 1, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, inst_we, core_reset, done, err;
  word_t inst_wr_addr, inst_wr_data;
  int total = 0, bad = 0, ready_bad = 0;
  word_t wq_a[$], wq_d[$];
  typedef struct {
    word_t n;
    logic [2:0][31:0] w;
    logic [7:0] cs;
    bit rnd;
    bit exp_done;
  } vec_t;
  vec_t tv[7];

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .inst_we(inst_we), .inst_wr_addr(inst_wr_addr),
    .inst_wr_data(inst_wr_data), .core_reset(core_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inst_we) begin
      wq_a.push_back(inst_wr_addr);
      wq_d.push_back(inst_wr_data);
      if (rx_ready) ready_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    int t = 0;
    if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("rx_ready_timeout", t, 0);
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic finish_load(input vec_t v);
    int t = 0;
    int nw;
    nw = (v.n <= 1024) ? int'(v.n) : 0;
    while (!(done || err) && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("end_timeout", t < 20, 1);
    chk("done", done, v.exp_done);
    chk("err", err, !v.exp_done);
    chk("core_reset", core_reset, !v.exp_done);
    chk("rx_ready_idle", rx_ready, 0);
    chk("nwrites", wq_a.size(), nw);
    for (int i = 0; i < nw && i < wq_a.size(); i++) begin
      chk("wr_addr", wq_a[i], 4 * i);
      chk("wr_data", wq_d[i], v.w[i]);
    end
  endtask

  task automatic run(input vec_t v, input bit mid_start);
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send(v.n[8*i +: 8], v.rnd);
    if (mid_start) pulse_start();
    if (v.n <= 1024) begin
      for (int w = 0; w < int'(v.n); w++)
        for (int b = 0; b < 4; b++) send(v.w[w][8*b +: 8], v.rnd);
      send(v.cs, v.rnd);
    end
    finish_load(v);
  endtask

  initial begin
    tv[0] = '{n: 1, w: {32'h0, 32'h0, 32'h0000_0013}, cs: 8'h13, rnd: 0, exp_done: 1};
    tv[1] = '{n: 2, w: {32'h0, 32'h0010_8113, 32'h0050_0093}, cs: 8'h41, rnd: 0, exp_done: 1};
    tv[2] = '{n: 1, w: {32'h0, 32'h0, 32'h0000_0013}, cs: 8'h12, rnd: 0, exp_done: 0};
    tv[3] = '{n: 1025, w: {32'h0, 32'h0, 32'h0}, cs: 8'h00, rnd: 0, exp_done: 0};
    tv[4] = '{n: 0, w: {32'h0, 32'h0, 32'h0}, cs: 8'h00, rnd: 0, exp_done: 1};
    tv[5] = '{n: 3, w: {32'hDEAD_BEEF, 32'hAABB_CCDD, 32'h1122_3344}, cs: 8'h66, rnd: 0, exp_done: 1};
    tv[6] = '{n: 3, w: {32'hDEAD_BEEF, 32'hAABB_CCDD, 32'h1122_3344}, cs: 8'h66, rnd: 1, exp_done: 1};
    repeat (2) @(negedge clk);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_done_err", {done, err, inst_we}, 0);
    chk("rst_addr", inst_wr_addr, 0);
    chk("rst_data", inst_wr_data, 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run(tv[i], 0);
    run(tv[1], 1);
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0);
    reset = 1;
    #1;
    chk("mid_rst_core_reset", core_reset, 1);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_flags", {done, err, inst_we}, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_nowrite", wq_a.size(), 0);
    run(tv[0], 0);
    chk("ready_in_write", ready_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
